// File: rtl/ram_march_bist.sv
// March-style RAM self-test engine.
// Runs four elements over the whole address space:
//   M0 write P ascending, M1 read P / write ~P ascending,
//   M2 read ~P / write P descending, M3 read P descending,
// then one drain cycle. The drain cycle lets the last read's data arrive and be compared.
// Mismatches are counted and never stop the run. The first mismatch is captured.
module ram_march_bist #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {
    StIdle, StM0, StM1R, StM1W, StM2R, StM2W, StM3R, StDrain
  } state_e;

  localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [4:0]        ErrMax   = 5'd31;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Pending-compare pipeline: set when a read is issued, checked one cycle later
  logic                chk_vld_q;
  logic [DATA_W-1:0]   chk_exp_q;
  logic [ADDR_W-1:0]   chk_addr_q;

  logic                done_q, pass_q;
  logic [4:0]          err_cnt_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [DATA_W-1:0]   fail_data_q;

  logic                rd_issue;
  logic [DATA_W-1:0]   rd_exp;
  logic                mismatch;
  logic                accept;

  assign accept   = (state_q == StIdle) && start;
  assign rd_issue = (state_q == StM1R) || (state_q == StM2R) || (state_q == StM3R);
  assign rd_exp   = (state_q == StM2R) ? ~PATTERN : PATTERN;
  assign mismatch = chk_vld_q && (ram_dout != chk_exp_q);

  // Next-state and address sequencing through the march elements
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start) state_d = StM0;
      end
      StM0: begin
        if (addr_q == AddrLast) begin
          state_d = StM1R;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AddrOne;
        end
      end
      StM1R: state_d = StM1W;
      StM1W: begin
        if (addr_q == AddrLast) begin
          state_d = StM2R;
          addr_d  = AddrLast;
        end else begin
          state_d = StM1R;
          addr_d  = addr_q + AddrOne;
        end
      end
      StM2R: state_d = StM2W;
      StM2W: begin
        if (addr_q == '0) begin
          state_d = StM3R;
          addr_d  = AddrLast;
        end else begin
          state_d = StM2R;
          addr_d  = addr_q - AddrOne;
        end
      end
      StM3R: begin
        if (addr_q == '0) begin
          state_d = StDrain;
          addr_d  = '0;
        end else begin
          addr_d = addr_q - AddrOne;
        end
      end
      StDrain: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase
  end

  // RAM control decoded from state only; no path from start or ram_dout
  always_comb begin
    ram_we  = 1'b0;
    ram_din = '0;
    case (state_q)
      StM0, StM2W: begin
        ram_we  = 1'b1;
        ram_din = PATTERN;
      end
      StM1W: begin
        ram_we  = 1'b1;
        ram_din = ~PATTERN;
      end
      default: ;
    endcase
  end

  assign ram_addr  = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

  // FSM, address and read-check pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      chk_vld_q  <= 1'b0;
      chk_exp_q  <= '0;
      chk_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      chk_vld_q  <= rd_issue;
      chk_exp_q  <= rd_exp;
      chk_addr_q <= addr_q;
    end
  end

  // Result registers: cleared on an accepted start, updated by compares, finalised leaving drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (accept) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt_q != ErrMax) err_cnt_q <= err_cnt_q + 5'd1;
        // Count is only zero before the first mismatch, so this captures once per run
        if (err_cnt_q == '0) begin
          fail_addr_q <= chk_addr_q;
          fail_data_q <= ram_dout;
        end
      end
      if (state_q == StDrain) begin
        done_q <= 1'b1;
        pass_q <= (err_cnt_q == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a 16x8 RAM model and selectable faults.
module tb_ram_march_bist;

  localparam logic [7:0] P = 8'h55;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;

  int checks = 0;
  int failures = 0;

  // 0: fault-free, 1: addr 5 bit0 stuck-at-1, 2: addr 9 ignores writes, 3: all reads 8'hFF
  int         mode = 0;
  logic       ram_clr = 1'b0;
  logic [7:0] mem [16];
  logic [7:0] rd_q;
  logic [3:0] rd_addr_q;

  ram_march_bist #(.DATA_W(8), .ADDR_W(4), .PATTERN(8'h55)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address is presented
  always_ff @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (ram_we && !(mode == 2 && ram_addr == 4'd9)) begin
      mem[ram_addr] <= ram_din;
    end
    rd_q      <= mem[ram_addr];
    rd_addr_q <= ram_addr;
  end

  always_comb begin
    ram_dout = rd_q;
    if (mode == 3) ram_dout = 8'hFF;
    else if (mode == 1 && rd_addr_q == 4'd5) ram_dout = rd_q | 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected RAM access for cycle k of a run (k=0 is the first M0 cycle)
  function automatic void exp_step(input int k, output logic we, output logic [3:0] a,
                                   output logic [7:0] d);
    int j;
    we = 1'b0;
    a  = 4'd0;
    d  = 8'h00;
    if (k < 16) begin
      we = 1'b1; a = 4'(k); d = P;
    end else if (k < 48) begin
      j = k - 16; a = 4'(j / 2); we = (j % 2) == 1; d = ~P;
    end else if (k < 80) begin
      j = k - 48; a = 4'(15 - j / 2); we = (j % 2) == 1; d = P;
    end else if (k < 96) begin
      a = 4'(15 - (k - 80));
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk); ram_clr = 1'b1;
    @(negedge clk); ram_clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run(input string tag, input int m, input bit trace, input bit repulse,
                     input logic exp_pass, input logic [4:0] exp_err,
                     input logic [3:0] exp_fa, input logic [7:0] exp_fd);
    int         k;
    logic       we_e;
    logic [3:0] a_e;
    logic [7:0] d_e;
    mode = m;
    pulse_start();
    k = 0;
    check({tag, "_clr_done"}, done, 0);
    check({tag, "_clr_err"}, err_cnt, 0);
    while (busy === 1'b1 && k < 120) begin
      if (trace && k < 97) begin
        exp_step(k, we_e, a_e, d_e);
        check($sformatf("%s_we_%0d", tag, k), ram_we, we_e);
        if (k < 96) check($sformatf("%s_addr_%0d", tag, k), ram_addr, a_e);
        if (we_e) check($sformatf("%s_din_%0d", tag, k), ram_din, d_e);
      end
      start = repulse && (k == 10 || k == 96);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_busy_len"}, k, 97);
    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_fail_addr"}, fail_addr, exp_fa);
    check({tag, "_fail_data"}, fail_data, exp_fd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_din"}, ram_din, 0);
    check({tag, "_faddr"}, fail_addr, 0);
    check({tag, "_fdata"}, fail_data, 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_addr", ram_addr, 0);

    run("clean", 0, 1'b1, 1'b0, 1'b1, 5'd0, 4'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("sticky_done", done, 1);
    check("sticky_pass", pass, 1);

    run("stuck5", 1, 1'b0, 1'b0, 1'b0, 5'd1, 4'd5, 8'hAB);
    run("nowr9", 2, 1'b0, 1'b0, 1'b0, 5'd3, 4'd9, 8'h00);
    run("allff", 3, 1'b0, 1'b0, 1'b0, 5'd31, 4'd0, 8'hFF);

    // Reset in the middle of a run
    mode = 0;
    pulse_start();
    repeat (40) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run("after_rst", 0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0, 8'h00);

    run("repulse", 0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd0, 8'h00);
    @(negedge clk);
    check("repulse_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width; DEPTH = 2^ADDR_W (16).
REQ-003 SHALL have parameter PATTERN, default 8'h55, background pattern P; ~P is its bitwise inverse.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to run one test.
REQ-007 SHALL have port ram_we  output  1  write enable to the RAM: 1 = write, 0 = read.
REQ-008 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-009 SHALL have port ram_din  output  DATA_W  RAM write data.
REQ-010 SHALL have port ram_dout  input  DATA_W  RAM read data, valid the cycle after the read is issued.
REQ-011 SHALL have port busy  output  1  test in progress.
REQ-012 SHALL have port done  output  1  sticky; test completed.
REQ-013 SHALL have port pass  output  1  sticky; completed with zero mismatches.
REQ-014 SHALL have port err_cnt  output  5  mismatch count, saturating at 31.
REQ-015 SHALL have port fail_addr  output  ADDR_W  address of the first mismatch.
REQ-016 SHALL have port fail_data  output  DATA_W  data read at the first mismatch.

Function
REQ-017 SHALL implement states IDLE, M0, M1R, M1W, M2R, M2W, M3R and DRAIN.
REQ-018 SHALL go from IDLE to M0 when start=1 is sampled; on that edge it SHALL clear done, pass, err_cnt, fail_addr and fail_data.
REQ-019 SHALL ignore start in every state except IDLE.
REQ-020 SHALL, in M0, write P at ascending addresses 0..DEPTH-1, one per cycle.
REQ-021 SHALL, in M1 (ascending), read address a in M1R, then write ~P to the same a in M1W.
REQ-022 SHALL, in M2 (descending DEPTH-1..0), read a in M2R, then write P to a in M2W.
REQ-023 SHALL, in M3 (descending), read a for one cycle per address, back-to-back.
REQ-024 SHALL step from M3R at address 0 to DRAIN for one cycle, with ram_we=0, then go to IDLE.
REQ-025 SHALL, when the last address of an element is reached, advance to the next element and load its start address (0 for ascending, DEPTH-1 for descending).
REQ-026 SHALL drive ram_we, ram_addr and ram_din only from state and internal registers, with no combinational path from start or ram_dout; in read states ram_din is don't-care.
REQ-027 SHALL, on every read issue, register check-valid, expected value and address, and compare against ram_dout in the following cycle.
REQ-028 SHALL use expected value P for M1R and M3R reads, and ~P for M2R reads.
REQ-029 SHALL, on a mismatch, increment err_cnt (saturating at 31); on the first mismatch of a run only, it SHALL capture fail_addr and fail_data.
REQ-030 SHALL NOT stop on a mismatch; the run always completes.
REQ-031 SHALL hold busy=1 for exactly 6*DEPTH+1 = 97 cycles, from the first M0 cycle through DRAIN.
REQ-032 SHALL, on the edge leaving DRAIN, set done=1 and set pass=1 only if err_cnt is 0 including the DRAIN compare; both hold until the next accepted start or reset.
REQ-033 SHALL drive ram_we=0 in IDLE, with ram_addr held at 0.

Reset
REQ-034 SHALL, while rst_n=0, immediately force: state IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, fail_data=0, check-valid=0.
REQ-035 SHALL, on reset mid-run, abandon the run with no completion flags; a fresh start is then required.

Verification
REQ-036 Fault-free 16x8 RAM model, start pulse -> busy for 97 cycles, then done=1, pass=1, err_cnt=0.
REQ-037 Model with addr 5 bit0 stuck-at-1 -> only the M2 read fails: err_cnt=1, fail_addr=5, fail_data=8'hAB, pass=0, done=1.
REQ-038 Model that ignores writes to addr 9 (init 8'h00) -> err_cnt=3 (reads in M1, M2, M3), fail_addr=9, fail_data=8'h00, pass=0.
REQ-039 rst_n low at cycle 40 of a run -> all outputs are 0 in the same cycle; after release, start -> full 97-cycle run with pass=1.
REQ-040 start re-pulsed at cycles 10 and 96 of a run -> no effect; the address/we trace is identical to REQ-036 (M0 0..15 writes; M1 R/W pairs 0..15; M2 pairs 15..0; M3 reads 15..0).
REQ-041 Model with every word returning 8'hFF -> err_cnt saturates at 31, fail_addr=0, fail_data=8'hFF.
